// File: rtl/reg_dump_reader.sv
// Streams a contiguous range of register-file entries out over a valid/ready port.
// The core is held off register writes while a dump is in progress.
module reg_dump_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADR_W-1:0]  first_adr,
  input  logic [ADR_W-1:0]  last_adr,
  output logic [ADR_W-1:0]  rd_adr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              hold_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADR_W-1:0]  out_adr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    cur_q, cur_d;
  logic [ADR_W-1:0]    end_q, end_d;
  logic [ADR_W-1:0]    rd_adr_q, rd_adr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADR_W-1:0]    out_adr_q, out_adr_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    rd_adr_d    = rd_adr_q;
    out_data_d  = out_data_q;
    out_adr_d   = out_adr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d = first_adr;
          end_d = last_adr;
          if (first_adr > last_adr) begin
            state_d = StDone;
          end else begin
            // rd_adr only moves when entering READ so it equals cur there
            rd_adr_d = first_adr;
            state_d  = StRead;
          end
        end
      end
      StRead: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else begin
          out_data_d  = rd_data;
          out_adr_d   = cur_q;
          out_last_d  = (cur_q == end_q);
          out_valid_d = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (cur_q == end_q) begin
            state_d = StDone;
          end else begin
            cur_d    = cur_q + ADR_W'(1);
            rd_adr_d = cur_q + ADR_W'(1);
            state_d  = StRead;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      end_q       <= '0;
      rd_adr_q    <= '0;
      out_data_q  <= '0;
      out_adr_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      rd_adr_q    <= rd_adr_d;
      out_data_q  <= out_data_d;
      out_adr_q   <= out_adr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_adr    = rd_adr_q;
  assign out_data  = out_data_q;
  assign out_adr   = out_adr_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign hold_req  = busy;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register file modelled as a lookup table,
// each scenario checks beats, timing and control outputs against hand-derived values.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_adr = '0;
  logic [4:0]  last_adr = '0;
  logic [4:0]  rd_adr;
  logic [31:0] rd_data;
  logic        hold_req;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_adr;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regfile [32];
  int tests = 0;
  int errors = 0;

  assign rd_data = regfile[rd_adr];

  always #5 clk = ~clk;

  reg_dump_reader #(.DATA_W(32), .ADR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_adr (first_adr),
    .last_adr  (last_adr),
    .rd_adr    (rd_adr),
    .rd_data   (rd_data),
    .hold_req  (hold_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_adr   (out_adr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; on return we are 1 time unit after that edge (cycle 1).
  task automatic issue(input logic [4:0] f, input logic [4:0] l);
    first_adr = f;
    last_adr  = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({out_valid, out_last, done, busy, hold_req} !== 5'b0 || rd_adr !== 5'd0 ||
        out_adr !== 5'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v%0b l%0b d%0b b%0b h%0b ra%0d oa%0d od%h want all 0",
               out_valid, out_last, done, busy, hold_req, rd_adr, out_adr, out_data);
    end
    rst_n = 1'b1;
    step();
    step();
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %0b want 0", busy);
    end
  endtask

  task automatic test_range_3_5;
    logic [4:0]  adrs [$];
    logic [31:0] datas [$];
    logic        lasts [$];
    int done_cyc = -1;
    int done_cnt = 0;
    out_ready = 1'b1;
    issue(5'd3, 5'd5);
    tests++;
    if (rd_adr !== 5'd3 || busy !== 1'b1 || hold_req !== 1'b1) begin
      errors++;
      $display("FAIL r35_read1: rd_adr %0d busy %0b hold %0b want 3 1 1", rd_adr, busy, hold_req);
    end
    for (int c = 1; c <= 12; c++) begin
      if (out_valid) begin
        adrs.push_back(out_adr);
        datas.push_back(out_data);
        lasts.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      step();
    end
    tests++;
    if (adrs.size() != 3) begin
      errors++;
      $display("FAIL r35_beats: got %0d beats want 3", adrs.size());
    end else begin
      tests++;
      if (adrs[0] !== 5'd3 || datas[0] !== 32'hA || lasts[0] !== 1'b0) begin
        errors++;
        $display("FAIL r35_beat0: got (%0d,%h,%0b) want (3,a,0)", adrs[0], datas[0], lasts[0]);
      end
      tests++;
      if (adrs[1] !== 5'd4 || datas[1] !== 32'hB || lasts[1] !== 1'b0) begin
        errors++;
        $display("FAIL r35_beat1: got (%0d,%h,%0b) want (4,b,0)", adrs[1], datas[1], lasts[1]);
      end
      tests++;
      if (adrs[2] !== 5'd5 || datas[2] !== 32'hC || lasts[2] !== 1'b1) begin
        errors++;
        $display("FAIL r35_beat2: got (%0d,%h,%0b) want (5,c,1)", adrs[2], datas[2], lasts[2]);
      end
    end
    tests++;
    if (done_cyc != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL r35_done: cycle %0d count %0d want cycle 7 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    out_ready = 1'b0;
    issue(5'd5, 5'd5);
    step();
    for (int c = 2; c <= 5; c++) begin
      if (out_valid !== 1'b1 || out_adr !== 5'd5 || out_data !== 32'hC || out_last !== 1'b1 ||
          done !== 1'b0)
        bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
    end
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || out_adr !== 5'd5 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_fifth: v%0b adr %0d l%0b want 1 5 1", out_valid, out_adr, out_last);
    end
    step();
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done %0b valid %0b want 1 0", done, out_valid);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: done %0b busy %0b want 0 0", done, busy);
    end
  endtask

  task automatic test_empty;
    out_ready = 1'b1;
    issue(5'd7, 5'd2);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_c1: done %0b busy %0b valid %0b want 1 1 0", done, busy, out_valid);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_c2: done %0b busy %0b valid %0b want 0 0 0", done, busy, out_valid);
    end
  endtask

  task automatic test_top_range;
    out_ready = 1'b1;
    issue(5'd30, 5'd31);
    step();
    tests++;
    if (out_valid !== 1'b1 || out_adr !== 5'd30 || out_data !== 32'h11E || out_last !== 1'b0) begin
      errors++;
      $display("FAIL top_beat0: v%0b (%0d,%h,%0b) want 1 (30,11e,0)",
               out_valid, out_adr, out_data, out_last);
    end
    step();
    tests++;
    if (rd_adr !== 5'd31) begin
      errors++;
      $display("FAIL top_rd31: rd_adr %0d want 31", rd_adr);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_adr !== 5'd31 || out_data !== 32'h11F || out_last !== 1'b1) begin
      errors++;
      $display("FAIL top_beat1: v%0b (%0d,%h,%0b) want 1 (31,11f,1)",
               out_valid, out_adr, out_data, out_last);
    end
    step();
    tests++;
    if (done !== 1'b1 || rd_adr !== 5'd31) begin
      errors++;
      $display("FAIL top_done: done %0b rd_adr %0d want 1 31", done, rd_adr);
    end
    step();
    tests++;
    if (rd_adr !== 5'd31 || out_adr !== 5'd31 || busy !== 1'b0) begin
      errors++;
      $display("FAIL top_nowrap: rd_adr %0d out_adr %0d busy %0b want 31 31 0",
               rd_adr, out_adr, busy);
    end
  endtask

  task automatic test_abort;
    int done_cnt = 0;
    out_ready = 1'b1;
    issue(5'd0, 5'd4);
    step();
    step();
    step();
    tests++;
    if (out_valid !== 1'b1 || out_adr !== 5'd1) begin
      errors++;
      $display("FAIL abort_second_send: v%0b adr %0d want 1 1", out_valid, out_adr);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: v%0b busy %0b done %0b want 0 0 0", out_valid, busy, done);
    end
    for (int c = 0; c < 4; c++) begin
      if (done || busy) done_cnt++;
      step();
    end
    tests++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_nodone: %0d active cycles want 0", done_cnt);
    end
    issue(5'd0, 5'd0);
    step();
    tests++;
    if (out_valid !== 1'b1 || out_adr !== 5'd0 || out_data !== 32'h0 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: v%0b (%0d,%h,%0b) want 1 (0,0,1)",
               out_valid, out_adr, out_data, out_last);
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart_done: done %0b want 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    issue(5'd3, 5'd5);
    step();
    issue(5'd9, 5'd9);
    tests++;
    if (out_valid !== 1'b1 || out_adr !== 5'd3 || rd_adr !== 5'd3) begin
      errors++;
      $display("FAIL ignore_start: v%0b out_adr %0d rd_adr %0d want 1 3 3",
               out_valid, out_adr, rd_adr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_last, done, busy, hold_req} !== 5'b0 || rd_adr !== 5'd0 ||
        out_adr !== 5'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got v%0b l%0b d%0b b%0b h%0b ra%0d oa%0d od%h want all 0",
               out_valid, out_last, done, busy, hold_req, rd_adr, out_adr, out_data);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy %0b valid %0b want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'h100 + i;
    regfile[0] = 32'h0;
    regfile[3] = 32'hA;
    regfile[4] = 32'hB;
    regfile[5] = 32'hC;
    test_reset();
    test_range_3_5();
    test_backpressure();
    test_empty();
    test_top_range();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
